// File: rtl/t_ff_count_ctrl_if.sv
// Bundles the control and bank-feedback signals between a T flip-flop bank
// counter controller and whatever drives and observes it.
//   master : drives start/stop/clear/up_dn and the bank feedback q_vec,
//            observes t_vec, busy, tc and state
//   slave  : the controller side (the mirror image of master)
interface t_ff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             up_dn;
    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             tc;
    logic [1:0]       state;

    modport master (
        output start, stop, clear, up_dn, q_vec,
        input  t_vec, busy, tc, state
    );

    modport slave (
        input  start, stop, clear, up_dn, q_vec,
        output t_vec, busy, tc, state
    );
endinterface

// File: rtl/t_ff_count_ctrl.sv
// Controller for an external bank of WIDTH T flip-flops that makes the bank
// count 0..MAX up or down. The controller never holds the count itself: it
// reads the bank back on q_vec and computes per-bit toggle enables on t_vec,
// so the bank moves on the same edge the controller decides.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; forces IDLE and clears tc
//   bus   : slave side of t_ff_count_ctrl_if
//           start/stop/clear/up_dn in, q_vec feedback in,
//           t_vec toggle enables, busy, tc wrap pulse and state out
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | bank untouched, waiting for start or clear
// RUN   | bank steps one count per clock in the up_dn direction
// HOLD  | counting paused, bank untouched
// CLR   | every set bank bit toggled until the bank reads zero
module t_ff_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input logic               clk,
    input logic               reset,
    t_ff_count_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        CLR  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] t_vec_c;
    logic             wrap;
    logic             tc_q;

    // Next count for the bank. Out-of-range values resync to the wrap target
    // of the current direction; only the up direction reports that as a wrap,
    // since counting down from >MAX lands on MAX without passing zero.
    always_comb begin
        next_cnt = bus.q_vec;
        wrap     = 1'b0;
        if (bus.up_dn) begin
            if (bus.q_vec >= MAX_V) begin
                next_cnt = '0;
                wrap     = 1'b1;
            end else begin
                next_cnt = bus.q_vec + 1'b1;
            end
        end else begin
            if (bus.q_vec == '0) begin
                next_cnt = MAX_V;
                wrap     = 1'b1;
            end else if (bus.q_vec > MAX_V) begin
                next_cnt = MAX_V;
            end else begin
                next_cnt = bus.q_vec - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= (state_q == RUN) && wrap;
        end
    end

    // Priority in every state is clear > stop > start.
    always_comb begin
        state_d = state_q;
        t_vec_c = '0;
        case (state_q)
            IDLE: begin
                if (bus.clear)      state_d = CLR;
                else if (bus.start) state_d = RUN;
            end
            RUN: begin
                t_vec_c = bus.q_vec ^ next_cnt;
                if (bus.clear)     state_d = CLR;
                else if (bus.stop) state_d = HOLD;
            end
            HOLD: begin
                if (bus.clear)      state_d = CLR;
                else if (bus.start) state_d = RUN;
            end
            CLR: begin
                // Toggling exactly the set bits zeroes the bank in one edge;
                // staying until zero is read back covers a bank that missed it.
                t_vec_c = bus.q_vec;
                if (bus.q_vec == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.t_vec = t_vec_c;
    assign bus.busy  = (state_q != IDLE);
    assign bus.tc    = tc_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
module tb_t_ff_count_ctrl;

    localparam int WIDTH = 4;
    localparam int MAX   = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    t_ff_count_ctrl_if #(.WIDTH(WIDTH)) bif ();

    t_ff_count_ctrl #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // Bank of T flip-flops fed by t_vec, with a preload path for the bench.
    logic [WIDTH-1:0] bank;
    logic [WIDTH-1:0] load_val;
    logic             load_en;
    always @(posedge clk) begin
        if (load_en) bank <= load_val;
        else         bank <= bank ^ bif.t_vec;
    end
    assign bif.q_vec = bank;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] st;
        logic [3:0] t;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void expect_out(input string nm, input logic [3:0] q,
                                       input logic [1:0] st, input logic [3:0] t,
                                       input logic tc, input logic busy);
        exp_t e;
        e.q = q; e.st = st; e.t = t; e.tc = tc; e.busy = busy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endfunction

    exp_t  mon_e;
    string mon_nm;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            checks++;
            if (bank !== mon_e.q || bif.state !== mon_e.st || bif.t_vec !== mon_e.t ||
                bif.tc !== mon_e.tc || bif.busy !== mon_e.busy) begin
                errors++;
                $display("FAIL %s: got q=%0d state=%0d t_vec=%b tc=%b busy=%b, want q=%0d state=%0d t_vec=%b tc=%b busy=%b",
                         mon_nm, bank, bif.state, bif.t_vec, bif.tc, bif.busy,
                         mon_e.q, mon_e.st, mon_e.t, mon_e.tc, mon_e.busy);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bank value in each RUN cycle: up to 9, wrap, down from 4 to 0,
    // wrap to 9, down once, back up through a second wrap, up to 6.
    logic [3:0] run_q [0:28] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9,
                                 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

    initial begin
        reset     = 1'b1;
        bif.start = 1'b0;
        bif.stop  = 1'b0;
        bif.clear = 1'b0;
        bif.up_dn = 1'b1;
        load_en   = 1'b1;
        load_val  = 4'd0;

        step();
        expect_out("reset", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        reset   = 1'b0;
        load_en = 1'b0;
        expect_out("idle_after_rst", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        expect_out("idle_wait", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        bif.start = 1'b1;
        expect_out("start_idle", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        bif.start = 1'b0;

        for (int k = 0; k < 28; k++) begin
            bif.up_dn = (k <= 13 || k >= 20);
            bif.stop  = (k == 27);
            expect_out($sformatf("run%0d", k), run_q[k], 2'b01, run_q[k] ^ run_q[k+1],
                       (k == 10 || k == 19 || k == 22), 1'b1);
            step();
        end
        bif.stop = 1'b0;

        expect_out("hold_enter", 4'd6, 2'b10, 4'd0, 1'b0, 1'b1);
        step();
        bif.stop = 1'b1;
        expect_out("hold_stop_ign", 4'd6, 2'b10, 4'd0, 1'b0, 1'b1);
        step();
        bif.stop  = 1'b0;
        bif.start = 1'b1;
        expect_out("hold_start", 4'd6, 2'b10, 4'd0, 1'b0, 1'b1);
        step();
        bif.start = 1'b0;
        expect_out("resume", 4'd6, 2'b01, 4'd1, 1'b0, 1'b1);
        step();
        bif.clear = 1'b1;
        expect_out("resume_7", 4'd7, 2'b01, 4'd15, 1'b0, 1'b1);
        step();
        bif.clear = 1'b0;
        expect_out("clr_from_run", 4'd8, 2'b11, 4'd8, 1'b0, 1'b1);
        step();
        expect_out("clr_zero", 4'd0, 2'b11, 4'd0, 1'b0, 1'b1);
        step();
        expect_out("clr_idle", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);

        load_en  = 1'b1;
        load_val = 4'd13;
        step();
        load_en   = 1'b0;
        bif.clear = 1'b1;
        expect_out("idle_13_clear", 4'd13, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        bif.clear = 1'b0;
        expect_out("clr13", 4'd13, 2'b11, 4'd13, 1'b0, 1'b1);
        step();
        expect_out("clr13_zero", 4'd0, 2'b11, 4'd0, 1'b0, 1'b1);
        step();
        expect_out("clr13_idle", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);

        load_en = 1'b1;
        step();
        load_en   = 1'b0;
        bif.clear = 1'b1;
        bif.start = 1'b1;
        bif.stop  = 1'b1;
        expect_out("idle_13_all", 4'd13, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        bif.clear = 1'b0;
        expect_out("clr13b", 4'd13, 2'b11, 4'd13, 1'b0, 1'b1);
        step();
        expect_out("clr13b_zero", 4'd0, 2'b11, 4'd0, 1'b0, 1'b1);
        step();
        bif.start = 1'b0;
        bif.stop  = 1'b0;
        expect_out("clr13b_idle", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);

        load_en   = 1'b1;
        load_val  = 4'd12;
        bif.up_dn = 1'b1;
        step();
        load_en   = 1'b0;
        bif.start = 1'b1;
        expect_out("idle_12", 4'd12, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        bif.start = 1'b0;
        expect_out("oob_up", 4'd12, 2'b01, 4'd12, 1'b0, 1'b1);
        step();
        bif.stop = 1'b1;
        expect_out("oob_wrap", 4'd0, 2'b01, 4'd1, 1'b1, 1'b1);
        step();
        bif.stop = 1'b0;
        load_en  = 1'b1;
        load_val = 4'd14;
        expect_out("hold_1", 4'd1, 2'b10, 4'd0, 1'b0, 1'b1);
        step();
        load_en   = 1'b0;
        bif.up_dn = 1'b0;
        bif.start = 1'b1;
        expect_out("hold_14", 4'd14, 2'b10, 4'd0, 1'b0, 1'b1);
        step();
        bif.start = 1'b0;
        expect_out("oob_dn", 4'd14, 2'b01, 4'd7, 1'b0, 1'b1);
        step();
        bif.up_dn = 1'b1;
        expect_out("dn_resync", 4'd9, 2'b01, 4'd9, 1'b0, 1'b1);
        step();
        reset = 1'b1;
        expect_out("rst_mid_run", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        expect_out("rst_held", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        expect_out("rst_rel", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        expect_out("rst_idle", 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        step();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_ff_count_ctrl.md
T_FF_COUNT_CTRL -- requirements
Module: t_ff_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, meaning width of the controlled T flip-flop bank (toggle vector and state feedback).
REQ-002 Parameter MAX, default 9, meaning terminal count; counting range is 0..MAX; MAX SHALL be < 2**WIDTH.
REQ-003 clk  input  1  meaning single system clock; all state changes on rising edge.
REQ-004 reset  input  1  meaning asynchronous, active-high reset.
REQ-005 start  input  1  meaning begin or resume counting.
REQ-006 stop  input  1  meaning pause counting (enter HOLD).
REQ-007 clear  input  1  meaning drive the bank to zero, then go idle.
REQ-008 up_dn  input  1  meaning count direction; 1 = up, 0 = down; sampled every RUN cycle.
REQ-009 q_vec  input  WIDTH  meaning current q outputs of the external T flip-flop bank.
REQ-010 t_vec  output  WIDTH  meaning per-bit toggle enables to the bank; bank bit i toggles on the next rising clk when t_vec[i]=1.
REQ-011 busy  output  1  meaning 1 whenever state is not IDLE.
REQ-012 tc  output  1  meaning registered one-cycle terminal-count (wrap) pulse.
REQ-013 state  output  2  meaning FSM state encoding: IDLE=00, RUN=01, HOLD=10, CLR=11.

Function
REQ-014 The FSM SHALL have exactly four states (IDLE, RUN, HOLD, CLR), registered on clk.
REQ-015 t_vec SHALL be combinational from state, q_vec and up_dn; no registered stage, so the bank update lands on the same edge the controller decides.
REQ-016 In IDLE and HOLD, t_vec SHALL be all zeros.
REQ-017 In RUN, t_vec SHALL equal q_vec XOR next, where next = q_vec+1 (0 if q_vec >= MAX) when up_dn=1, and q_vec-1 (MAX if q_vec = 0 or q_vec > MAX) when up_dn=0.
REQ-018 In CLR, t_vec SHALL equal q_vec, so all set bits toggle to zero on the next edge.
REQ-019 Input priority in every state SHALL be clear > stop > start.
REQ-020 IDLE: clear -> CLR; else start -> RUN; else stay.
REQ-021 RUN: clear -> CLR; else stop -> HOLD; else stay; start is ignored.
REQ-022 HOLD: clear -> CLR; else start -> RUN; else stay; stop is ignored.
REQ-023 CLR: when q_vec = 0, go to IDLE (t_vec already zero); else stay in CLR. Start and stop are ignored.
REQ-024 tc SHALL be set on an edge where state=RUN and a wrap occurs: up with q_vec >= MAX, or down with q_vec = 0. tc is cleared on every other edge (single-cycle pulse).
REQ-025 Out-of-range q_vec (> MAX) in RUN SHALL resynchronise in one cycle: to 0 counting up, to MAX counting down. Counting up also asserts tc.
REQ-026 A direction change (up_dn toggling) mid-RUN SHALL take effect on the same cycle, with no idle cycle.

Reset
REQ-027 While reset=1, state SHALL be IDLE and tc=0, asynchronously, regardless of clk.
REQ-028 As a consequence, t_vec=0 and busy=0 immediately on reset assertion, including mid-RUN or mid-CLR. The bank's own reset is separate and is not driven by this block.
REQ-029 After reset deassertion, the block SHALL remain in IDLE until start or clear is sampled.

Verification
REQ-030 Bench SHALL model the bank as WIDTH T flip-flops fed by t_vec, with q_vec fed back.
REQ-031 Reset, then start with up_dn=1, bank at 0 -> q_vec steps 1,2,...,9,0 on successive edges; tc=1 for exactly the cycle after the 9->0 edge; busy=1 throughout.
REQ-032 Running up at q_vec=4, up_dn set to 0 -> q_vec goes 3,2,1,0,9; tc pulses once after the 0->9 edge.
REQ-033 Running at q_vec=6, stop asserted for one cycle -> state=HOLD, t_vec=0, q_vec holds 6; start -> counting resumes at 7.
REQ-034 At q_vec=13 (0b1101), clear asserted -> t_vec=1101 in CLR, q_vec=0 next edge, then IDLE; busy falls. Repeat with start and stop asserted in the same cycle as clear -> clear wins.
REQ-035 Bank preloaded to 12 (> MAX), start, up -> next q_vec=0 with tc pulse. Also: reset asserted between clock edges mid-RUN -> t_vec=0, state=00, tc=0 immediately.
